mips_cpu_muldiv_iter: RTL and testbench



---
 rtl/mips_cpu_muldiv_iter.sv | 152 +++++++++++++++
 tb/tb_mips_cpu_muldiv_iter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_cpu_muldiv_iter.sv
// Iterative MULT/MULTU/DIV/DIVU unit for the HI/LO path (start/busy/done).
// Ports: clk, reset (async high), start, op, a, b -> busy, done, hi, lo.
// Option: define MULDIV_EARLY_TERM_EN to end multiplies once the
// remaining multiplier bits are all zero.
module mips_cpu_muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  state_t state, state_nx;

  logic               div_q;
  logic               sa, sb;
  logic               sa_n, sb_n;
  logic [WIDTH-1:0]   ma, mb, a_raw;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;

  // mult step: add into upper half with carry, then shift right
  logic [WIDTH:0]     msum;
  logic [WIDTH-1:0]   mb_sh;
  // div step: remainder lives in acc upper half, ma shifts
  // dividend out of the top and quotient bits in at the bottom
  logic [WIDTH:0]     rsh;
  logic [WIDTH:0]     rdiff;
  logic               r_ge;
  logic               last;
  logic               calc_exit;

  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] mres;
  logic [WIDTH-1:0]   qres, rres;

  assign sa_n  = a[WIDTH-1] & op[0];
  assign sb_n  = b[WIDTH-1] & op[0];

  assign msum  = {1'b0, acc[2*WIDTH-1:WIDTH]}
               + {1'b0, (mb[0] ? ma : '0)};
  assign mb_sh = mb >> 1;

  assign rsh   = {acc[2*WIDTH-1:WIDTH], ma[WIDTH-1]};
  assign rdiff = rsh - {1'b0, mb};
  assign r_ge  = rsh >= {1'b0, mb};

  assign last  = cnt == CW'(WIDTH - 1);

`ifdef MULDIV_EARLY_TERM_EN
  assign calc_exit = last | (~div_q & (mb_sh == '0));
  // an early exit leaves the product short of its final shifts
  assign prod      = acc >> (CW'(WIDTH) - cnt);
`else
  assign calc_exit = last;
  assign prod      = acc;
`endif

  assign mres = (sa ^ sb) ? -prod : prod;
  assign qres = (sa ^ sb) ? -ma : ma;
  assign rres = sa ? -acc[2*WIDTH-1:WIDTH]
                   : acc[2*WIDTH-1:WIDTH];

  assign busy = (state == CALC) | (state == FIX);
  assign done = state == DONE;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start) state_nx = CALC;
      CALC: if (calc_exit) state_nx = FIX;
      FIX:  state_nx = DONE;
      DONE: state_nx = start ? CALC : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q <= 1'b0;
      sa    <= 1'b0;
      sb    <= 1'b0;
      ma    <= '0;
      mb    <= '0;
      a_raw <= '0;
      acc   <= '0;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            div_q <= op[1];
            sa    <= sa_n;
            sb    <= sb_n;
            ma    <= sa_n ? -a : a;
            mb    <= sb_n ? -b : b;
            a_raw <= a;
            acc   <= '0;
            cnt   <= '0;
          end
        end
        CALC: begin
          cnt <= cnt + 1'b1;
          if (!div_q) begin
            acc <= {msum, acc[WIDTH-1:1]};
            mb  <= mb_sh;
          end else begin
            acc[2*WIDTH-1:WIDTH] <= r_ge ? rdiff[WIDTH-1:0]
                                         : rsh[WIDTH-1:0];
            ma <= {ma[WIDTH-2:0], r_ge};
          end
        end
        FIX: begin
          if (!div_q) begin
            {hi, lo} <= mres;
          end else if (mb == '0) begin
            hi <= a_raw;
            lo <= '1;
          end else begin
            hi <= rres;
            lo <= qres;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_cpu_muldiv_iter.sv
// Self-checking bench for mips_cpu_muldiv_iter (WIDTH=32): directed
// cases, handshake/reset scenarios and random ops vs a reference model.
module tb_mips_cpu_muldiv_iter;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   op = 2'd0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mips_cpu_muldiv_iter #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .a(a), .b(b), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  function automatic void model(
    input logic [1:0] mop, input logic [31:0] ma, input logic [31:0] mb,
    output logic [31:0] ehi, output logic [31:0] elo);
    logic [63:0] p;
    longint la, lb, q, r;
    if (!mop[1]) begin
      if (mop[0])
        p = longint'($signed(ma)) * longint'($signed(mb));
      else
        p = {32'b0, ma} * {32'b0, mb};
      ehi = p[63:32];
      elo = p[31:0];
    end else if (mb == 32'd0) begin
      ehi = ma;
      elo = 32'hFFFF_FFFF;
    end else begin
      la = mop[0] ? longint'($signed(ma)) : longint'({32'b0, ma});
      lb = mop[0] ? longint'($signed(mb)) : longint'({32'b0, mb});
      q = la / lb;
      r = la % lb;
      p = q;
      elo = p[31:0];
      p = r;
      ehi = p[31:0];
    end
  endfunction

  // edges from the start edge until done is visible
  function automatic int exp_lat(input logic [1:0] mop, input logic [31:0] mb);
`ifdef MULDIV_EARLY_TERM_EN
    logic [31:0] m;
    int n;
    if (mop[1]) return W + 1;
    m = (mop[0] && mb[31]) ? -mb : mb;
    n = 0;
    for (int i = 0; i < W; i++) if (m[i]) n = i + 1;
    return ((n < 1) ? 1 : n) + 1;
`else
    return W + 1;
`endif
  endfunction

  task automatic do_op(
    input logic [1:0] iop, input logic [31:0] ia, input logic [31:0] ib,
    output logic [31:0] rhi, output logic [31:0] rlo,
    output int lat, output int nbusy, output bit got);
    @(negedge clk);
    start = 1'b1; op = iop; a = ia; b = ib;
    @(posedge clk); #1;
    start = 1'b0;
    op = 2'($urandom); a = $urandom; b = $urandom;
    lat = 0; nbusy = 0; got = 0;
    rhi = '0; rlo = '0;
    if (busy) nbusy++;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      lat++;
      if (done) begin
        got = 1; rhi = hi; rlo = lo;
        break;
      end
      if (busy) nbusy++;
    end
  endtask

  task automatic check_op(
    input string nm, input logic [1:0] iop,
    input logic [31:0] ia, input logic [31:0] ib,
    input logic [31:0] ehi, input logic [31:0] elo);
    logic [31:0] rhi, rlo;
    int lat, nb, el;
    bit got;
    do_op(iop, ia, ib, rhi, rlo, lat, nb, got);
    el = exp_lat(iop, ib);
    total++;
    if (!got) begin
      bad++;
      $display("FAIL %s timeout: no done", nm);
      return;
    end
    if (rhi !== ehi || rlo !== elo) begin
      bad++;
      $display("FAIL %s op=%0d a=%h b=%h got hi=%h lo=%h want hi=%h lo=%h",
               nm, iop, ia, ib, rhi, rlo, ehi, elo);
    end
    total++;
    if (lat != el || nb != el) begin
      bad++;
      $display("FAIL %s latency got=%0d busy=%0d want=%0d", nm, lat, nb, el);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2;
    total++;
    if (busy !== 0 || done !== 0 || hi !== 0 || lo !== 0) begin
      bad++;
      $display("FAIL reset got busy=%b done=%b hi=%h lo=%h want 0",
               busy, done, hi, lo);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_directed();
    logic [1:0]  t_op[11] = '{0, 1, 1, 3, 2, 3, 3, 2, 3, 0, 1};
    logic [31:0] t_a[11] = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'h80000000,
      32'hFFFFFFF9, 32'h7, 32'h7, 32'h80000000, 32'h5, 32'hFFFFFFF9,
      32'h0, 32'h7FFFFFFF};
    logic [31:0] t_b[11] = '{32'hFFFFFFFF, 32'h7, 32'h80000000,
      32'h2, 32'h2, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h0, 32'h0,
      32'h0, 32'hFFFFFFFF};
    logic [31:0] t_hi[11] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h40000000,
      32'hFFFFFFFF, 32'h1, 32'h1, 32'h0, 32'h5, 32'hFFFFFFF9,
      32'h0, 32'hFFFFFFFF};
    logic [31:0] t_lo[11] = '{32'h00000001, 32'hFFFFFFEB, 32'h0,
      32'hFFFFFFFD, 32'h3, 32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF,
      32'hFFFFFFFF, 32'h0, 32'h80000001};
    for (int i = 0; i < 11; i++)
      check_op($sformatf("directed%0d", i), t_op[i], t_a[i], t_b[i],
               t_hi[i], t_lo[i]);
  endtask

  task automatic test_ignore_start();
    int nd, k;
    logic [31:0] rhi, rlo;
`ifdef MULDIV_EARLY_TERM_EN
    k = 2;
`else
    k = 5;
`endif
    @(negedge clk);
    start = 1'b1; op = 2'd0; a = 32'd3; b = 32'd4;
    @(posedge clk); #1;
    start = 1'b0;
    nd = 0; rhi = '0; rlo = '0;
    repeat (k) @(posedge clk);
    @(negedge clk);
    start = 1'b1; a = 32'd9; b = 32'd9; op = 2'd3;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 45; i++) begin
      @(posedge clk); #1;
      if (done) begin
        nd++; rhi = hi; rlo = lo;
      end
    end
    total++;
    if (nd != 1) begin
      bad++;
      $display("FAIL ignore_start done pulses got=%0d want=1", nd);
    end
    total++;
    if (rhi !== 32'h0 || rlo !== 32'hC) begin
      bad++;
      $display("FAIL ignore_start got hi=%h lo=%h want hi=0 lo=c", rhi, rlo);
    end
  endtask

  task automatic test_reset_mid();
    int nd;
    @(negedge clk);
    start = 1'b1; op = 2'd0; a = 32'd123; b = 32'hFFFFFFFF;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    total++;
    if (busy !== 0 || done !== 0 || hi !== 0 || lo !== 0) begin
      bad++;
      $display("FAIL reset_mid got busy=%b done=%b hi=%h lo=%h want 0",
               busy, done, hi, lo);
    end
    @(negedge clk);
    reset = 1'b0;
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done || busy) nd++;
    end
    total++;
    if (nd != 0) begin
      bad++;
      $display("FAIL reset_mid activity after reset got=%0d want=0", nd);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ehi, elo;
    // each op starts on the negedge of the previous op's DONE cycle
    model(2'd1, 32'hFFFF1234, 32'h00ABCDEF, ehi, elo);
    check_op("b2b_first", 2'd1, 32'hFFFF1234, 32'h00ABCDEF, ehi, elo);
    model(2'd3, 32'h87654321, 32'h00000013, ehi, elo);
    check_op("b2b_second", 2'd3, 32'h87654321, 32'h00000013, ehi, elo);
  endtask

`ifdef MULDIV_EARLY_TERM_EN
  task automatic test_early_term();
    check_op("early_5x3", 2'd0, 32'd5, 32'd3, 32'h0, 32'hF);
    check_op("early_full", 2'd0, 32'd2, 32'hFFFFFFFF, 32'h1, 32'hFFFFFFFE);
    check_op("early_zero", 2'd1, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h0);
  endtask
`endif

  task automatic test_random();
    logic [1:0]  rop;
    logic [31:0] ra, rb, ehi, elo;
    for (int i = 0; i < 1000; i++) begin
      rop = 2'($urandom);
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = $urandom_range(0, 15);
        2: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
        3: ra = $urandom_range(0, 255);
        default: ;
      endcase
      model(rop, ra, rb, ehi, elo);
      check_op($sformatf("random%0d", i), rop, ra, rb, ehi, elo);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
`ifdef MULDIV_EARLY_TERM_EN
    test_early_term();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
